// File: rtl/com4_rx_framer.sv
// Receive front end of the 4-byte UART command channel: 8N1 deserialiser, sync-byte
// hunt, payload + XOR checksum collection and atomic commit to DATA0..DATA3.
module com4_rx_framer #(
  parameter int         CLKS_PER_BIT = 104,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 20000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] DATA0,
  output logic [7:0] DATA1,
  output logic [7:0] DATA2,
  output logic [7:0] DATA3,
  output logic       FRAME_VALID,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CLKS);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [2:0] {
    F_HUNT = 3'd0,
    F_B0   = 3'd1,
    F_B1   = 3'd2,
    F_B2   = 3'd3,
    F_B3   = 3'd4,
    F_CHK  = 3'd5
  } frame_state_t;

  function automatic logic [7:0] frame_checksum(input logic [3:0][7:0] payload);
    frame_checksum = payload[0] ^ payload[1] ^ payload[2] ^ payload[3];
  endfunction

  // Bit receiver state
  logic             rx_meta_r, rx_sync_r;
  rx_state_t        rx_state_r, rx_state_s;
  logic [CNT_W-1:0] bit_cnt_r, bit_cnt_s;
  logic [2:0]       bit_idx_r, bit_idx_s;
  logic [7:0]       shift_r, shift_s;
  logic             byte_strobe_r, byte_strobe_s;
  logic             byte_err_r, byte_err_s;

  // Frame state
  frame_state_t     frame_state_r, frame_state_s;
  logic [3:0][7:0]  shadow_r, shadow_s;
  logic [3:0][7:0]  data_r, data_s;
  logic [TMO_W-1:0] timer_r, timer_s;
  logic             frame_valid_r, frame_valid_s;
  logic             frame_err_r, frame_err_s;
  logic             busy_r, busy_s;
  logic             abort_s;

  // Bit receiver next-state: half-bit start check, then one sample per bit period.
  always_comb begin
    rx_state_s    = rx_state_r;
    bit_cnt_s     = bit_cnt_r;
    bit_idx_s     = bit_idx_r;
    shift_s       = shift_r;
    byte_strobe_s = 1'b0;
    byte_err_s    = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        bit_cnt_s = {CNT_W{1'b0}};
        bit_idx_s = 3'd0;
        if (!rx_sync_r) begin
          rx_state_s = RX_START;
        end else begin
          rx_state_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (bit_cnt_r == HALF_LAST) begin
          bit_cnt_s = {CNT_W{1'b0}};
          if (rx_sync_r) begin
            rx_state_s = RX_IDLE;
          end else begin
            rx_state_s = RX_DATA;
          end
        end else begin
          bit_cnt_s = bit_cnt_r + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (bit_cnt_r == BIT_LAST) begin
          bit_cnt_s = {CNT_W{1'b0}};
          shift_s   = {rx_sync_r, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            rx_state_s = RX_STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          bit_cnt_s = bit_cnt_r + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (bit_cnt_r == BIT_LAST) begin
          bit_cnt_s  = {CNT_W{1'b0}};
          rx_state_s = RX_IDLE;
          if (rx_sync_r) begin
            byte_strobe_s = 1'b1;
          end else begin
            byte_err_s = 1'b1;
          end
        end else begin
          bit_cnt_s = bit_cnt_r + CNT_W'(1);
        end
      end
      default: begin
        rx_state_s = RX_IDLE;
        bit_cnt_s  = {CNT_W{1'b0}};
      end
    endcase
  end

  // Bit receiver registers, including the two-flop RX synchroniser.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta_r     <= 1'b1;
      rx_sync_r     <= 1'b1;
      rx_state_r    <= RX_IDLE;
      bit_cnt_r     <= {CNT_W{1'b0}};
      bit_idx_r     <= 3'd0;
      shift_r       <= 8'h00;
      byte_strobe_r <= 1'b0;
      byte_err_r    <= 1'b0;
    end else begin
      rx_meta_r     <= RX;
      rx_sync_r     <= rx_meta_r;
      rx_state_r    <= rx_state_s;
      bit_cnt_r     <= bit_cnt_s;
      bit_idx_r     <= bit_idx_s;
      shift_r       <= shift_s;
      byte_strobe_r <= byte_strobe_s;
      byte_err_r    <= byte_err_s;
    end
  end

  // shift_r holds the received byte from the strobe until the next byte's first data bit.
  always_comb begin
    frame_state_s = frame_state_r;
    shadow_s      = shadow_r;
    data_s        = data_r;
    frame_valid_s = 1'b0;
    frame_err_s   = 1'b0;
    abort_s       = byte_err_r || (timer_r == TMO_LIMIT);
    case (frame_state_r)
      F_HUNT: begin
        if (byte_strobe_r && (shift_r == SYNC_BYTE)) begin
          frame_state_s = F_B0;
        end else begin
          frame_state_s = F_HUNT;
        end
      end
      F_B0: begin
        if (byte_strobe_r) begin
          shadow_s[0]   = shift_r;
          frame_state_s = F_B1;
        end else if (abort_s) begin
          frame_err_s   = 1'b1;
          frame_state_s = F_HUNT;
        end else begin
          frame_state_s = F_B0;
        end
      end
      F_B1: begin
        if (byte_strobe_r) begin
          shadow_s[1]   = shift_r;
          frame_state_s = F_B2;
        end else if (abort_s) begin
          frame_err_s   = 1'b1;
          frame_state_s = F_HUNT;
        end else begin
          frame_state_s = F_B1;
        end
      end
      F_B2: begin
        if (byte_strobe_r) begin
          shadow_s[2]   = shift_r;
          frame_state_s = F_B3;
        end else if (abort_s) begin
          frame_err_s   = 1'b1;
          frame_state_s = F_HUNT;
        end else begin
          frame_state_s = F_B2;
        end
      end
      F_B3: begin
        if (byte_strobe_r) begin
          shadow_s[3]   = shift_r;
          frame_state_s = F_CHK;
        end else if (abort_s) begin
          frame_err_s   = 1'b1;
          frame_state_s = F_HUNT;
        end else begin
          frame_state_s = F_B3;
        end
      end
      F_CHK: begin
        if (byte_strobe_r) begin
          frame_state_s = F_HUNT;
          if (shift_r == frame_checksum(shadow_r)) begin
            data_s        = shadow_r;
            frame_valid_s = 1'b1;
          end else begin
            frame_err_s = 1'b1;
          end
        end else if (abort_s) begin
          frame_err_s   = 1'b1;
          frame_state_s = F_HUNT;
        end else begin
          frame_state_s = F_CHK;
        end
      end
      default: begin
        frame_state_s = F_HUNT;
      end
    endcase

    // Timer counts cycles since the last strobe, the strobe cycle itself being zero.
    if (frame_state_s == F_HUNT) begin
      timer_s = {TMO_W{1'b0}};
    end else if (byte_strobe_r) begin
      timer_s = TMO_W'(1);
    end else begin
      timer_s = timer_r + TMO_W'(1);
    end
    busy_s = (frame_state_s != F_HUNT);
  end

  // Frame registers and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_state_r <= F_HUNT;
      shadow_r      <= {4{8'h00}};
      data_r        <= {4{8'h00}};
      timer_r       <= {TMO_W{1'b0}};
      frame_valid_r <= 1'b0;
      frame_err_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      frame_state_r <= frame_state_s;
      shadow_r      <= shadow_s;
      data_r        <= data_s;
      timer_r       <= timer_s;
      frame_valid_r <= frame_valid_s;
      frame_err_r   <= frame_err_s;
      busy_r        <= busy_s;
    end
  end

  assign DATA0       = data_r[0];
  assign DATA1       = data_r[1];
  assign DATA2       = data_r[2];
  assign DATA3       = data_r[3];
  assign FRAME_VALID = frame_valid_r;
  assign FRAME_ERR   = frame_err_r;
  assign BUSY        = busy_r;

endmodule

// File: tb/tb_com4_rx_framer.sv
// Randomised bench for com4_rx_framer: a byte/frame-level reference model predicts
// every output on every cycle, plus directed scenarios pinned with literal values.
module tb_com4_rx_framer;

  localparam int         CPB  = 8;
  localparam int         TMO  = 400;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX  = 1'b1;
  logic [7:0] DATA0, DATA1, DATA2, DATA3;
  logic       FRAME_VALID, FRAME_ERR, BUSY;

  com4_rx_framer #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(SYNC), .TIMEOUT_CLKS(TMO)) dut (
    .CLK(CLK), .RST(RST), .RX(RX),
    .DATA0(DATA0), .DATA1(DATA1), .DATA2(DATA2), .DATA3(DATA3),
    .FRAME_VALID(FRAME_VALID), .FRAME_ERR(FRAME_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // cyc = number of rising edges so far; outputs of cycle n are those after edge n.
  int   cyc = 0;
  logic rst_q = 1'b0;
  always @(posedge CLK) begin
    cyc   <= cyc + 1;
    rst_q <= RST;
  end

  typedef struct {
    int         s;   // edge at which the receiver samples the stop bit
    logic [7:0] d;
    bit         ok;
  } rxb_t;
  rxb_t rx_q[$];

  int n_cmp = 0, n_bad = 0;
  int vcnt = 0, ecnt = 0, v_cyc = 0, e_cyc = 0, s_last = 0;

  // Reference model: frame position 0 = hunting, 1..4 = expecting payload, 5 = checksum.
  int         m_pos = 0;
  int         m_last = 0;
  logic [7:0] m_sh [4];
  logic [31:0] m_data = 32'h0;
  logic       m_valid = 1'b0, m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    rxb_t rb;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (rst_q) begin
      m_pos  = 0;
      m_data = 32'h0;
      rx_q.delete();
    end else if (rx_q.size() > 0 && rx_q[0].s + 1 == cyc) begin
      rb = rx_q.pop_front();
      if (m_pos == 0) begin
        if (rb.ok && rb.d == SYNC) begin
          m_pos  = 1;
          m_last = rb.s;
        end
      end else if (!rb.ok) begin
        m_err = 1'b1;
        m_pos = 0;
      end else if (m_pos <= 4) begin
        m_sh[m_pos-1] = rb.d;
        m_pos++;
        m_last = rb.s;
      end else begin
        if (rb.d == (m_sh[0] ^ m_sh[1] ^ m_sh[2] ^ m_sh[3])) begin
          m_data  = {m_sh[0], m_sh[1], m_sh[2], m_sh[3]};
          m_valid = 1'b1;
        end else begin
          m_err = 1'b1;
        end
        m_pos = 0;
      end
    end else if (m_pos != 0 && cyc == m_last + TMO + 1) begin
      m_err = 1'b1;
      m_pos = 0;
    end
  endtask

  // Single compare process: model advances one cycle, then every output is checked.
  always @(negedge CLK) begin
    if (cyc >= 1) begin
      model_step();
      chk("FRAME_VALID", 32'(FRAME_VALID), 32'(m_valid));
      chk("FRAME_ERR", 32'(FRAME_ERR), 32'(m_err));
      chk("BUSY", 32'(BUSY), 32'(m_pos != 0));
      chk("DATA", {DATA0, DATA1, DATA2, DATA3}, m_data);
      if (FRAME_VALID === 1'b1) begin
        vcnt++;
        v_cyc = cyc;
      end
      if (FRAME_ERR === 1'b1) begin
        ecnt++;
        e_cyc = cyc;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Called #1 after a rising edge. Start bit reaches the receiver after two
  // synchroniser flops plus one detect edge; then half a bit and nine full bits.
  task automatic send_byte(input logic [7:0] d, input bit stop_ok);
    rxb_t       e;
    logic [9:0] fr;
    fr   = {stop_ok, d, 1'b0};
    e.s  = cyc + 3 + CPB / 2 + 9 * CPB;
    e.d  = d;
    e.ok = stop_ok;
    rx_q.push_back(e);
    s_last = e.s;
    for (int i = 0; i < 10; i++) begin
      RX = fr[i];
      repeat (CPB) @(posedge CLK);
      #1;
    end
    RX = 1'b1;
    if (!stop_ok) idle(2 * CPB);
  endtask

  task automatic send_frame(input logic [7:0] p0, p1, p2, p3, ck);
    send_byte(SYNC, 1'b1);
    send_byte(p0, 1'b1);
    send_byte(p1, 1'b1);
    send_byte(p2, 1'b1);
    send_byte(p3, 1'b1);
    send_byte(ck, 1'b1);
  endtask

  int         v0, e0, mode, j, k, nn;
  logic [7:0] fb [6];
  logic [7:0] b;

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    idle(10);
    chk("reset_data", {DATA0, DATA1, DATA2, DATA3}, 32'h0);
    chk("reset_busy", 32'(BUSY), 32'h0);

    // Good frame
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
    idle(5);
    chk("t1_data", {DATA0, DATA1, DATA2, DATA3}, 32'h11223344);
    chk("t1_valid_cnt", 32'(vcnt - v0), 32'd1);
    chk("t1_err_cnt", 32'(ecnt - e0), 32'd0);
    chk("t1_latency", 32'(v_cyc - (s_last - 1)), 32'd2);

    // Bad checksum, then recovery
    e0 = ecnt;
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h00);
    idle(5);
    chk("t2_err_cnt", 32'(ecnt - e0), 32'd1);
    chk("t2_data_kept", {DATA0, DATA1, DATA2, DATA3}, 32'h11223344);
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
    idle(5);
    chk("t2_data", {DATA0, DATA1, DATA2, DATA3}, 32'h01020304);

    // Noise bytes and a short glitch ahead of a good frame
    v0 = vcnt; e0 = ecnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    RX = 1'b0;
    idle(2);
    RX = 1'b1;
    idle(20);
    send_frame(8'h5A, 8'hC3, 8'h3C, 8'h99, 8'h3C);
    idle(5);
    chk("t3_data", {DATA0, DATA1, DATA2, DATA3}, 32'h5AC33C99);
    chk("t3_err_cnt", 32'(ecnt - e0), 32'd0);
    chk("t3_valid_cnt", 32'(vcnt - v0), 32'd1);

    // Stop-bit error on the third payload byte
    e0 = ecnt;
    send_byte(SYNC, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h30, 1'b0);
    idle(5);
    chk("t4_err_cnt", 32'(ecnt - e0), 32'd1);
    chk("t4_busy", 32'(BUSY), 32'h0);
    chk("t4_data_kept", {DATA0, DATA1, DATA2, DATA3}, 32'h5AC33C99);

    // Inter-byte timeout, then a good frame
    send_byte(SYNC, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h20, 1'b1);
    idle(500);
    chk("t5_timeout_delay", 32'(e_cyc - s_last), 32'd401);
    send_frame(8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h00);
    idle(5);
    chk("t5_data", {DATA0, DATA1, DATA2, DATA3}, 32'h0A0B0C0D);

    // Reset while collecting B2
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
    send_byte(SYNC, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle(20);
    chk("t6_busy_before", 32'(BUSY), 32'h1);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    chk("t6_data_reset", {DATA0, DATA1, DATA2, DATA3}, 32'h0);
    chk("t6_busy_reset", 32'(BUSY), 32'h0);
    idle(10);
    send_frame(8'h55, 8'h66, 8'h77, 8'h88, 8'hCC);
    idle(5);
    chk("t6_data", {DATA0, DATA1, DATA2, DATA3}, 32'h55667788);

    // Randomised frames: good, bad checksum, stop-bit error, truncated (timeout)
    for (int i = 0; i < 30; i++) begin
      mode = $urandom_range(0, 3);
      nn   = $urandom_range(0, 2);
      for (int n = 0; n < nn; n++) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        send_byte(b, 1'b1);
      end
      fb[0] = SYNC;
      for (int n = 1; n < 5; n++) fb[n] = 8'($urandom);
      fb[5] = fb[1] ^ fb[2] ^ fb[3] ^ fb[4];
      if (mode == 1) fb[5] = fb[5] ^ 8'($urandom_range(1, 255));
      j = (mode == 2) ? $urandom_range(0, 5) : 6;
      k = (mode == 3) ? $urandom_range(2, 5) : 6;
      for (int n = 0; n < k; n++) send_byte(fb[n], n != j);
      if (mode == 3) idle(TMO + 50);
      idle($urandom_range(0, 30));
    end
    idle(TMO + 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/com4_rx_framer.md
# com4_rx_framer

- Receive-side front end of the 4-byte UART command channel.
- Deserialises 8N1 bytes from the `RX` pin and hunts for a sync byte.
- Collects four payload bytes plus an XOR checksum, then commits the payload atomically to four parallel byte registers.
- Its registers feed the `DATA_IN0..DATA_IN3` inputs of the user logic. Malformed, corrupted or stalled frames are dropped and flagged, never partially applied.

## Interface

Parameters:
- `CLKS_PER_BIT`, 104 — `CLK` cycles per UART bit (12 MHz / 115200). Minimum 4.
- `SYNC_BYTE`, 8'hA5 — frame start marker.
- `TIMEOUT_CLKS`, 20000 — maximum idle `CLK` cycles allowed between consecutive bytes inside a frame.

Ports:
- `CLK` in 1 — single clock for all logic.
- `RST` in 1 — synchronous, active-high reset.
- `RX` in 1 — asynchronous UART line; idles high.
- `DATA0`..`DATA3` out 8 each — last committed payload bytes.
- `FRAME_VALID` out 1 — one-cycle pulse when `DATA0..3` update.
- `FRAME_ERR` out 1 — one-cycle pulse when a frame is aborted.
- `BUSY` out 1 — high whenever the frame FSM is not in HUNT.

## Operation

Reset:
- `DATA0..3` = 0; `FRAME_VALID`, `FRAME_ERR` and `BUSY` = 0.
- Both synchroniser flops = 1; bit FSM in IDLE; frame FSM in HUNT.
- Reset asserted mid-byte or mid-frame discards all partial state. `DATA0..3` return to 0.

Bit receiver:
- Input path is a 2-flop synchroniser on `RX`.
- IDLE: a synchronised low starts the half-bit counter.
- START: at `CLKS_PER_BIT/2` (integer division) re-sample the line. If high, it was a glitch: return to IDLE, no byte. If low, go to DATA.
- DATA: sample every `CLKS_PER_BIT` cycles, 8 bits, LSB first.
- STOP: sample one bit later.
  - 1 → issue an internal `byte_strobe` with the byte.
  - 0 → issue `byte_err`; the byte is discarded.
  - Either way return to IDLE the cycle after the sample, so back-to-back bytes with no idle gap are accepted.

Frame FSM (`HUNT` → `B0` → `B1` → `B2` → `B3` → `CHK`):
- HUNT: a byte equal to `SYNC_BYTE` moves to B0; any other byte is ignored without error. `byte_err` in HUNT is ignored.
- B0..B3: each strobe stores the byte into a shadow register and advances. B3 goes to CHK.
- CHK: on strobe, compare the byte to `B0^B1^B2^B3`.
  - Match: copy all four shadows to `DATA0..3` in the same cycle, pulse `FRAME_VALID`, go to HUNT.
  - Mismatch: pulse `FRAME_ERR`, leave `DATA0..3` unchanged, go to HUNT.
- Abort rules in B0..CHK: each of the following pulses `FRAME_ERR` and returns to HUNT, with `DATA0..3` unchanged.
  - `byte_err` received.
  - Inter-byte timeout: a counter, cleared on every strobe, reaches `TIMEOUT_CLKS`.
- A payload or checksum byte equal to `SYNC_BYTE` is treated as data; there is no resync inside a frame.
- After an abort, the next `SYNC_BYTE` starts a new frame.
- `FRAME_VALID` and `FRAME_ERR` are never high in the same cycle.

## Timing

- `byte_strobe` / `byte_err` are registered 1 cycle after the stop-bit sample cycle.
- `DATA0..3`, `FRAME_VALID` and `FRAME_ERR` are registered 1 cycle after `byte_strobe`. The checksum stop-bit sample at cycle k therefore yields outputs at k+2.
- Timeout `FRAME_ERR` asserts the cycle after the counter reaches `TIMEOUT_CLKS`.
- `BUSY` rises the cycle after the sync byte's strobe. It falls in the same cycle `FRAME_VALID` or `FRAME_ERR` is high.
- Minimum frame duration is 6 × 10 × `CLKS_PER_BIT` cycles. Sustained back-to-back frames must not be dropped.
- `DATA0..3` hold their value indefinitely between valid frames.

## Test plan

Bench runs with `CLKS_PER_BIT`=8 and `TIMEOUT_CLKS`=400.

1. **Good frame:** send A5 11 22 33 44 44 (checksum 0x44) → `DATA0..3` = 11/22/33/44, one `FRAME_VALID` pulse exactly 2 cycles after the final stop sample, `FRAME_ERR` never high.
2. **Bad checksum then recovery:** send A5 01 02 03 04 00 → one `FRAME_ERR` pulse, `DATA` unchanged. Then send A5 01 02 03 04 04 → `DATA` = 01/02/03/04.
3. **Noise and glitches:** send 00 FF A5 before a good frame, plus a 2-cycle low glitch on `RX` → no error, no spurious byte, frame accepted normally.
4. **Stop-bit error:** force `RX`=0 during the stop bit of the third payload byte → `FRAME_ERR`, `BUSY` drops, `DATA` unchanged.
5. **Timeout:** send A5 10 20, then idle 500 cycles → `FRAME_ERR` 401 cycles after the last strobe. A subsequent complete frame is accepted.
6. **Reset mid-frame:** after `DATA` = 11/22/33/44, assert `RST` for 1 cycle in the middle of B2 → all outputs 0 next cycle, FSM in HUNT, `DATA` = 0. The next good frame commits correctly.
